// File: rtl/i2c_fifo.sv
// Synchronous first-word-fall-through byte FIFO between the I2C register block
// and the bit-level controller, with count-decoded status and sticky error flags.
module i2c_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       write_enable,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       read_enable,
  output logic [DATA_W-1:0]          rdata,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              wr_ok;
  logic              rd_ok;

  // A write at full is still taken when a read frees the head in the same cycle.
  always_comb begin
    wr_ok = write_enable && (!full || read_enable);
    rd_ok = read_enable && !empty;
  end

  always_comb begin
    empty       = (cnt == '0);
    full        = (cnt == CW'(DEPTH));
    almost_full = (cnt >= CW'(AF_LEVEL));
    count       = cnt;
    rdata       = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (write_enable && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (read_enable && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
